// File: rtl/ula_sequencial.sv
// Registered WIDTH-bit ALU with START/READY/DONE handshake.
// Optional shift-add multiplier for OP=110 enabled by defining ULA_MUL_EN.
module ula_sequencial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             ILLEGAL
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

`ifdef ULA_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;

  // Single-cycle datapath; SUB reuses the adder as A + ~B + 1.
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;
  logic             alu_ill;

  always_comb begin
    addend   = (OP == OP_SUB) ? ~B : B;
    sum      = {1'b0, A} + {1'b0, addend} + {{WIDTH{1'b0}}, (OP == OP_SUB)};
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    case (OP)
      OP_ADD, OP_SUB: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = (A[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOT:  alu_res = ~A;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
`ifndef ULA_MUL_EN
      OP_MUL:  alu_ill = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef ULA_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcd_q, mcd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mpl_q, mpl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] mpl_nx;

  // One shift-add step: the carry joins the accumulator before the right shift.
  always_comb begin
    mul_sum = {1'b0, acc_q} + {1'b0, (mcd_q & {WIDTH{mpl_q[0]}})};
    acc_nx  = mul_sum[WIDTH:1];
    mpl_nx  = {mul_sum[0], mpl_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    hi_d      = hi_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
`ifdef ULA_MUL_EN
    mcd_d     = mcd_q;
    acc_d     = acc_q;
    mpl_d     = mpl_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
`ifdef ULA_MUL_EN
          if (OP == OP_MUL) begin
            mcd_d   = A;
            mpl_d   = B;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_MUL;
          end else
`endif
          begin
            result_d  = alu_res;
            hi_d      = '0;
            cout_d    = alu_cout;
            ovf_d     = alu_ovf;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
`ifdef ULA_MUL_EN
      S_MUL: begin
        acc_d = acc_nx;
        mpl_d = mpl_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d  = mpl_nx;
          hi_d      = acc_nx;
          cout_d    = 1'b0;
          ovf_d     = 1'b0;
          zero_d    = ({acc_nx, mpl_nx} == '0);
          illegal_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      hi_q      <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef ULA_MUL_EN
      mcd_q     <= '0;
      acc_q     <= '0;
      mpl_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
`ifdef ULA_MUL_EN
      mcd_q     <= mcd_d;
      acc_q     <= acc_d;
      mpl_q     <= mpl_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign READY     = (state_q == S_IDLE);
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign RESULT_HI = hi_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;
  assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_ula_sequencial.sv
// Self-checking bench for ula_sequencial (WIDTH=8); covers both ULA_MUL_EN builds.
module tb_ula_sequencial;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START;
  logic [2:0] OP;
  logic [7:0] A;
  logic [7:0] B;
  logic       READY;
  logic       DONE;
  logic [7:0] RESULT;
  logic [7:0] RESULT_HI;
  logic       COUT;
  logic       OVF;
  logic       ZERO;
  logic       ILLEGAL;

  ula_sequencial #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .A(A), .B(B),
    .READY(READY), .DONE(DONE), .RESULT(RESULT), .RESULT_HI(RESULT_HI),
    .COUT(COUT), .OVF(OVF), .ZERO(ZERO), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       ill;
    int         lat;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model from the arithmetic definitions, not the adder structure.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, s;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    e.res = 8'h00; e.hi = 8'h00; e.cout = 1'b0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1;
    case (op)
      3'd0: begin
        s = ua + ub;
        e.res  = 8'(s % 256);
        e.cout = (s > 255);
        e.ovf  = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      3'd1: begin
        s = ua - ub + 256;
        e.res  = 8'(s % 256);
        e.cout = (ua >= ub);
        e.ovf  = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = ~a;
      3'd6: begin
`ifdef ULA_MUL_EN
        s = ua * ub;
        e.res = 8'(s % 256);
        e.hi  = 8'(s / 256);
        e.lat = 9;
`else
        e.ill = 1'b1;
`endif
      end
      default: e.res = (sa < sb) ? 8'd1 : 8'd0;
    endcase
    e.zero = (e.res == 8'h00) && (e.hi == 8'h00);
    return e;
  endfunction

  function automatic vec_t mkv(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] res, input logic [7:0] hi, input logic cout,
                               input logic ovf, input logic zero, input logic ill, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    v.e.res = res; v.e.hi = hi; v.e.cout = cout; v.e.ovf = ovf;
    v.e.zero = zero; v.e.ill = ill; v.e.lat = lat;
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (READY !== 1'b1 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    if (READY !== 1'b1) chk({tag, "_ready_timeout"}, 32'(READY), 32'd1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_res"},   32'(RESULT),    32'd0);
    chk({tag, "_hi"},    32'(RESULT_HI), 32'd0);
    chk({tag, "_cout"},  32'(COUT),      32'd0);
    chk({tag, "_ovf"},   32'(OVF),       32'd0);
    chk({tag, "_zero"},  32'(ZERO),      32'd0);
    chk({tag, "_ill"},   32'(ILLEGAL),   32'd0);
    chk({tag, "_done"},  32'(DONE),      32'd0);
    chk({tag, "_ready"}, 32'(READY),     32'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e, input string tag);
    int lat;
    bit got;
    @(negedge CLK);
    wait_ready(tag);
    START = 1'b1; OP = op; A = a; B = b;
    @(posedge CLK);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      lat++;
      @(negedge CLK);
      START = 1'b0;
      if (DONE === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge CLK);
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_res"},     32'(RESULT),    32'(e.res));
      chk({tag, "_hi"},      32'(RESULT_HI), 32'(e.hi));
      chk({tag, "_cout"},    32'(COUT),      32'(e.cout));
      chk({tag, "_ovf"},     32'(OVF),       32'(e.ovf));
      chk({tag, "_zero"},    32'(ZERO),      32'(e.zero));
      chk({tag, "_ill"},     32'(ILLEGAL),   32'(e.ill));
      chk({tag, "_lat"},     32'(lat),       32'(e.lat));
      chk({tag, "_busy"},    32'(READY),     32'd0);
      @(negedge CLK);
      chk({tag, "_done1"},   32'(DONE),      32'd0);
      chk({tag, "_readyup"}, 32'(READY),     32'd1);
      chk({tag, "_held"},    32'(RESULT),    32'(e.res));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    exp_t e;
    int lat;
    bit got;
    int pulses;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    RST_N = 1'b0; START = 1'b0; OP = 3'd0; A = 8'h00; B = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk_rst("por");

    vecs.push_back(mkv(3'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 0, 1, 0, 1));
    vecs.push_back(mkv(3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 0, 1, 0, 0, 1));
    vecs.push_back(mkv(3'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 1, 1, 0, 0, 1));
    vecs.push_back(mkv(3'd1, 8'h05, 8'h07, 8'hFE, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(3'd1, 8'h07, 8'h07, 8'h00, 8'h00, 1, 0, 1, 0, 1));
    vecs.push_back(mkv(3'd7, 8'h80, 8'h01, 8'h01, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(3'd7, 8'h01, 8'h80, 8'h00, 8'h00, 0, 0, 1, 0, 1));
    vecs.push_back(mkv(3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(3'd3, 8'hF0, 8'h0F, 8'hFF, 8'h00, 0, 0, 0, 0, 1));
`ifdef ULA_MUL_EN
    vecs.push_back(mkv(3'd6, 8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 0, 0, 0, 9));
    vecs.push_back(mkv(3'd6, 8'h0C, 8'h0A, 8'h78, 8'h00, 0, 0, 0, 0, 9));
    vecs.push_back(mkv(3'd6, 8'h00, 8'h5A, 8'h00, 8'h00, 0, 0, 1, 0, 9));
`else
    vecs.push_back(mkv(3'd6, 8'h03, 8'h04, 8'h00, 8'h00, 0, 0, 1, 1, 1));
`endif
    vecs.push_back(mkv(3'd4, 8'hAA, 8'hFF, 8'h55, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(3'd5, 8'h0F, 8'h33, 8'hF0, 8'h00, 0, 0, 0, 0, 1));

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));

    // START raised while in the DONE cycle must be dropped.
    @(negedge CLK);
    wait_ready("dstart");
    START = 1'b1; OP = 3'd0; A = 8'h10; B = 8'h20;
    @(posedge CLK);
    @(negedge CLK);
    chk("dstart_done", 32'(DONE), 32'd1);
    chk("dstart_res", 32'(RESULT), 32'h30);
    START = 1'b1; OP = 3'd3; A = 8'h0F; B = 8'hF0;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    chk("dstart_nodone", 32'(DONE), 32'd0);
    chk("dstart_ready", 32'(READY), 32'd1);
    chk("dstart_held", 32'(RESULT), 32'h30);
    @(posedge CLK);
    @(negedge CLK);
    chk("dstart_nodone2", 32'(DONE), 32'd0);
    chk("dstart_held2", 32'(RESULT), 32'h30);

    run_op(3'd0, 8'h7F, 8'h01, model(3'd0, 8'h7F, 8'h01), "prerst");
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk_rst("rstclr");

`ifdef ULA_MUL_EN
    run_op(3'd0, 8'h12, 8'h34, model(3'd0, 8'h12, 8'h34), "pre_mul");
    @(negedge CLK);
    wait_ready("mulhold");
    START = 1'b1; OP = 3'd6; A = 8'hFF; B = 8'hFF;
    @(posedge CLK);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      lat++;
      @(negedge CLK);
      if (DONE === 1'b1) begin
        START = 1'b0;
        got = 1'b1;
        break;
      end
      chk("mulhold_ready", 32'(READY), 32'd0);
      chk("mulhold_res", 32'(RESULT), 32'h46);
      chk("mulhold_hi", 32'(RESULT_HI), 32'h00);
      START = 1'b1; OP = 3'd0; A = 8'h01; B = 8'h01;
      @(posedge CLK);
    end
    START = 1'b0;
    chk("mulhold_done_seen", 32'(got), 32'd1);
    chk("mulhold_lat", 32'(lat), 32'd9);
    chk("mulhold_res_fin", 32'(RESULT), 32'h01);
    chk("mulhold_hi_fin", 32'(RESULT_HI), 32'hFE);
    chk("mulhold_zero", 32'(ZERO), 32'd0);
    chk("mulhold_ill", 32'(ILLEGAL), 32'd0);
    @(negedge CLK);
    chk("mulhold_done1", 32'(DONE), 32'd0);
    chk("mulhold_readyup", 32'(READY), 32'd1);
    @(negedge CLK);
    chk("mulhold_noqueue", 32'(DONE), 32'd0);
    chk("mulhold_keep", 32'(RESULT), 32'h01);

    // Reset after four iterations of 0x0C*0x0A.
    wait_ready("mulrst");
    START = 1'b1; OP = 3'd6; A = 8'h0C; B = 8'h0A;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("mulrst_predone", 32'(DONE), 32'd0);
    chk("mulrst_prehi", 32'(RESULT_HI), 32'hFE);
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk_rst("mulrst");
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) pulses++;
    end
    chk("mulrst_nopulse", 32'(pulses), 32'd0);
    run_op(3'd2, 8'hF0, 8'h3C, model(3'd2, 8'hF0, 8'h3C), "post_mulrst");
`endif

    for (int i = 0; i < 200; i++) begin
      rop = 3'($urandom_range(7, 0));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (i % 16 == 0) ra = 8'h80;
      if (i % 16 == 1) rb = 8'hFF;
      e = model(rop, ra, rb);
      run_op(rop, ra, rb, e, $sformatf("rnd%0d_op%0d_%02h_%02h", i, rop, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
